// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming 3x3 window generator with two line buffers, raster counters and row-fill state machine
module sobel_window_gen #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int DATA_W     = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pix_valid,
   input  logic [DATA_W-1:0]             pix_in,
   input  logic                          sof,
   output logic                          win_valid,
   output logic [DATA_W-1:0]             P0,
   output logic [DATA_W-1:0]             P1,
   output logic [DATA_W-1:0]             P2,
   output logic [DATA_W-1:0]             P3,
   output logic [DATA_W-1:0]             P4,
   output logic [DATA_W-1:0]             P5,
   output logic [DATA_W-1:0]             P6,
   output logic [DATA_W-1:0]             P7,
   output logic [DATA_W-1:0]             P8,
   output logic [$clog2(IMG_WIDTH)-1:0]  col_out,
   output logic [$clog2(IMG_HEIGHT)-1:0] row_out
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   typedef enum logic [1:0] {FILL0, FILL1, ACTIVE} state_t;

   state_t              r_state, w_state, w_state_nxt;
   logic [CW-1:0]       r_col, w_col, w_col_nxt;
   logic [RW-1:0]       r_row, w_row, w_row_nxt;
   logic                w_last_col, w_last_row, w_win_ok;
   logic [DATA_W-1:0]   r_lb1 [IMG_WIDTH];
   logic [DATA_W-1:0]   r_lb2 [IMG_WIDTH];
   logic [DATA_W-1:0]   w_lb1, w_lb2;
   logic [DATA_W-1:0]   r_win [9];
   logic                r_valid;
   logic [CW-1:0]       r_col_out;
   logic [RW-1:0]       r_row_out;

   // sof re-anchors the current pixel to (0,0) in FILL0; then compute next position, next state and window validity
   always_comb begin
      w_state     = sof ? FILL0 : r_state;
      w_col       = sof ? '0 : r_col;
      w_row       = sof ? '0 : r_row;
      w_last_col  = w_col == CW'(IMG_WIDTH - 1);
      w_last_row  = w_row == RW'(IMG_HEIGHT - 1);
      w_col_nxt   = w_last_col ? '0 : w_col + CW'(1);
      w_row_nxt   = !w_last_col ? w_row : (w_last_row ? '0 : w_row + RW'(1));
      w_state_nxt = w_state;
      if (w_last_col)
         w_state_nxt = (w_state == FILL0) ? FILL1 :
                       (w_state == FILL1) ? ACTIVE :
                       (w_last_row ? FILL0 : ACTIVE);
      w_win_ok    = (w_state == ACTIVE) && (w_col >= CW'(2));
      w_lb1       = r_lb1[w_col];
      w_lb2       = r_lb2[w_col];
   end

   // raster counters and fill state advance only on accepted pixels
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col   <= '0;
         r_row   <= '0;
         r_state <= FILL0;
      end else if (pix_valid) begin
         r_col   <= w_col_nxt;
         r_row   <= w_row_nxt;
         r_state <= w_state_nxt;
      end
   end

   // line buffers: old row y-1 moves down to y-2, new pixel becomes row y-1 (read-before-write, never cleared)
   always_ff @(posedge clk) begin
      if (!rst && pix_valid) begin
         r_lb2[w_col] <= r_lb1[w_col];
         r_lb1[w_col] <= pix_in;
      end
   end

   // window shifts left on each accepted pixel; validity and centre coordinate registered alongside
   always_ff @(posedge clk) begin
      if (rst) begin
         r_win     <= '{default: '0};
         r_valid   <= 1'b0;
         r_col_out <= '0;
         r_row_out <= '0;
      end else begin
         r_valid <= pix_valid && w_win_ok;
         if (pix_valid) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_lb2;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_lb1;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= pix_in;
            if (w_win_ok) begin
               r_col_out <= w_col - CW'(1);
               r_row_out <= w_row - RW'(1);
            end
         end
      end
   end

   assign win_valid = r_valid;
   assign P0        = r_win[0];
   assign P1        = r_win[1];
   assign P2        = r_win[2];
   assign P3        = r_win[3];
   assign P4        = r_win[4];
   assign P5        = r_win[5];
   assign P6        = r_win[6];
   assign P7        = r_win[7];
   assign P8        = r_win[8];
   assign col_out   = r_col_out;
   assign row_out   = r_row_out;
endmodule
